// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  typedef logic [3:0]  nibble_t;
  typedef logic [6:0]  seg_t;
  typedef int unsigned width_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_HEX [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Counter width for a count of n; never narrower than one bit.
  function automatic width_t idxWidth(input int unsigned n);
    return (n > 1) ? width_t'($clog2(n)) : width_t'(1);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-low seven-segment pattern, purely combinational.
module seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode display driver with a double-buffered value.
// Define SEVEN_SEG_LZ_BLANK_EN to blank leading zero digits.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = int'(idxWidth(DIGITS));
  localparam int DIV_W = int'(idxWidth(SCAN_DIV));
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadowVal_q, shadowVal_d;
  logic [DIGITS-1:0]   shadowDp_q, shadowDp_d;
  logic [4*DIGITS-1:0] pendVal_q, pendVal_d;
  logic [DIGITS-1:0]   pendDp_q, pendDp_d;
  logic                pend_q, pend_d;
  logic                boundDly_q, boundDly_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frameDone_q, frameDone_d;

  logic                tick;
  logic                boundary;
  logic [3:0]          curNibble;
  logic [6:0]          decSeg;
  logic                curBlank;

  assign curNibble = shadowVal_q[{idx_q, 2'b00} +: 4];

  seg_decode u_decode (
    .nibble_i (curNibble),
    .seg_o    (decSeg)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] lzBlank;

  // A digit is blank when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    logic zeroRun;
    zeroRun = 1'b1;
    lzBlank = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zeroRun    = zeroRun & (shadowVal_q[4*k +: 4] == 4'h0);
      lzBlank[k] = zeroRun;
    end
  end

  assign curBlank = lzBlank[idx_q];
`else
  assign curBlank = 1'b0;
`endif

  always_comb begin
    div_d       = div_q;
    idx_d       = idx_q;
    shadowVal_d = shadowVal_q;
    shadowDp_d  = shadowDp_q;
    pendVal_d   = pendVal_q;
    pendDp_d    = pendDp_q;
    pend_d      = pend_q;
    tick        = 1'b0;
    boundary    = 1'b0;

    if (!enable) begin
      div_d = '0;
      idx_d = '0;
      if (load) begin
        shadowVal_d = value;
        shadowDp_d  = dp_in;
        pend_d      = 1'b0;
      end
    end else begin
      tick     = (div_q == DIV_LAST);
      boundary = tick && (idx_q == IDX_LAST);
      if (tick) begin
        div_d = '0;
        idx_d = boundary ? '0 : idx_q + IDX_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end

      // A live load on the boundary beats an older pending value.
      if (boundary && load) begin
        shadowVal_d = value;
        shadowDp_d  = dp_in;
        pend_d      = 1'b0;
      end else if (boundary && pend_q) begin
        shadowVal_d = pendVal_q;
        shadowDp_d  = pendDp_q;
        pend_d      = 1'b0;
      end else if (load) begin
        pendVal_d = value;
        pendDp_d  = dp_in;
        pend_d    = 1'b1;
      end
    end
  end

  // The boundary is delayed twice so frame_done lands with digit 0 on the pins.
  always_comb begin
    seg_d       = SEG_BLANK;
    dp_d        = 1'b1;
    an_d        = '1;
    boundDly_d  = boundary;
    frameDone_d = boundDly_q & enable;
    if (enable) begin
      seg_d       = curBlank ? SEG_BLANK : decSeg;
      dp_d        = ~shadowDp_q[idx_q];
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      idx_q       <= '0;
      shadowVal_q <= '0;
      shadowDp_q  <= '0;
      pendVal_q   <= '0;
      pendDp_q    <= '0;
      pend_q      <= 1'b0;
      boundDly_q  <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      an_q        <= '1;
      frameDone_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      shadowVal_q <= shadowVal_d;
      shadowDp_q  <= shadowDp_d;
      pendVal_q   <= pendVal_d;
      pendDp_q    <= pendDp_d;
      pend_q      <= pend_d;
      boundDly_q  <= boundDly_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frameDone_q;

endmodule
